// File: rtl/heap_array_pkg.sv
// Shared types and default sizing for the array-aware heap stage.
package heap_array_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 12;
    localparam int unsigned DEF_N_ARRAYS   = 2;
    localparam int unsigned DEF_N_AREA     = 2;

    typedef enum logic [2:0] {
        OP_ALLOC = 3'd0,
        OP_FREE  = 3'd1,
        OP_READ  = 3'd2,
        OP_WRITE = 3'd3,
        OP_SIZE  = 3'd4
    } heap_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CLR  = 2'd2,
        ST_RESP = 2'd3
    } heap_state_t;

    // Index width for an n-entry structure, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/heap_array_controller_ram.sv
// heap_ram: single-port synchronous RAM, write-first, registered read.
module heap_ram
    import heap_array_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_N_ARRAYS * DEF_N_AREA,
    parameter int unsigned ADDR_WIDTH = idx_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write-first: a write also returns the new data on the read port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/heap_array_controller.sv
// Array-aware heap stage: ALLOC/FREE/READ/WRITE/SIZE over valid/ready,
// owning the freed-handle stack, allocation counter, sizes and heap RAM.
// Optional build macro HEAP_ZERO_ON_ALLOC_EN: a successful ALLOC zeroes the
// array area one element per cycle before responding.
module heap_array_controller
    import heap_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned N_ARRAYS   = DEF_N_ARRAYS,
    parameter int unsigned N_AREA     = DEF_N_AREA
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_array,
    input  logic [DATA_WIDTH-1:0] req_index,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] allocs
);

    localparam int unsigned DEPTH = N_ARRAYS * N_AREA;
    localparam int unsigned AW    = idx_width(DEPTH);
    localparam int unsigned HW    = idx_width(N_ARRAYS);
    localparam int unsigned SW    = $clog2(N_ARRAYS + 1);
    localparam int unsigned DW1   = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] N_ARRAYS_W = DATA_WIDTH'(N_ARRAYS);
    localparam logic [DATA_WIDTH-1:0] N_AREA_W   = DATA_WIDTH'(N_AREA);

    heap_state_t           state;
    logic [N_ARRAYS-1:0]   live_q;
    logic [DATA_WIDTH-1:0] size_q  [N_ARRAYS];
    logic [HW-1:0]         stack_q [N_ARRAYS];
    logic [SW-1:0]         top_q;
    logic                  rd_ok_q;
`ifdef HEAP_ZERO_ON_ALLOC_EN
    logic [DATA_WIDTH-1:0] clr_cnt_q;
    logic [DATA_WIDTH-1:0] clr_base_q;
`endif

    heap_op_t              op;
    logic                  accept;
    logic                  live;
    logic                  elem_ok;
    logic [HW-1:0]         hidx;
    logic [DW1-1:0]        new_size;
    logic                  alloc_pop;
    logic                  alloc_new;
    logic [HW-1:0]         alloc_handle;

    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Request decode: bounds checks, grown size and next handle to issue.
    always_comb begin
        op           = heap_op_t'(req_op);
        accept       = req_valid && req_ready;
        hidx         = HW'(req_array);
        live         = (req_array < N_ARRAYS_W) && live_q[hidx];
        elem_ok      = live && (req_index < N_AREA_W);
        new_size     = {1'b0, req_index} + DW1'(1);
        if (new_size < {1'b0, size_q[hidx]}) begin
            new_size = {1'b0, size_q[hidx]};
        end
        alloc_pop    = (top_q != '0);
        alloc_new    = !alloc_pop && (allocs < N_ARRAYS_W);
        alloc_handle = alloc_pop ? stack_q[HW'(top_q - SW'(1))] : HW'(allocs);
    end

    // RAM port: request address in IDLE (read issued at acceptance), clear in CLR.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = AW'(req_array * N_AREA_W + req_index);
        ram_wdata = req_data;
        if (state == ST_IDLE) begin
            ram_we = accept && (op == OP_WRITE) && elem_ok;
        end
`ifdef HEAP_ZERO_ON_ALLOC_EN
        if (state == ST_CLR) begin
            ram_we    = 1'b1;
            ram_addr  = AW'(clr_base_q + clr_cnt_q);
            ram_wdata = '0;
        end
`endif
    end

    heap_ram #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Controller FSM with registered handshake/response outputs and heap state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
            allocs     <= '0;
            live_q     <= '0;
            top_q      <= '0;
            rd_ok_q    <= 1'b0;
            for (int k = 0; k < N_ARRAYS; k++) begin
                size_q[k]  <= '0;
                stack_q[k] <= '0;
            end
`ifdef HEAP_ZERO_ON_ALLOC_EN
            clr_cnt_q  <= '0;
            clr_base_q <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_error <= 1'b0;
                        state      <= ST_RESP;
                        case (op)
                            OP_ALLOC: begin
                                if (alloc_pop || alloc_new) begin
                                    if (alloc_pop) top_q <= top_q - SW'(1);
                                    if (alloc_new) allocs <= allocs + DATA_WIDTH'(1);
                                    live_q[alloc_handle] <= 1'b1;
                                    size_q[alloc_handle] <= '0;
                                    resp_data            <= DATA_WIDTH'(alloc_handle);
`ifdef HEAP_ZERO_ON_ALLOC_EN
                                    resp_valid <= 1'b0;
                                    state      <= ST_CLR;
                                    clr_cnt_q  <= '0;
                                    clr_base_q <= DATA_WIDTH'(alloc_handle) * N_AREA_W;
`endif
                                end else begin
                                    resp_error <= 1'b1;
                                end
                            end
                            OP_FREE: begin
                                if (live) begin
                                    live_q[hidx]        <= 1'b0;
                                    stack_q[HW'(top_q)] <= hidx;
                                    top_q               <= top_q + SW'(1);
                                end else begin
                                    resp_error <= 1'b1;
                                end
                            end
                            OP_READ: begin
                                resp_valid <= 1'b0;
                                rd_ok_q    <= elem_ok;
                                state      <= ST_RD;
                            end
                            OP_WRITE: begin
                                if (elem_ok) begin
                                    size_q[hidx] <= DATA_WIDTH'(new_size);
                                end else begin
                                    resp_error <= 1'b1;
                                end
                            end
                            OP_SIZE: begin
                                if (live) begin
                                    resp_data <= size_q[hidx];
                                end else begin
                                    resp_error <= 1'b1;
                                end
                            end
                            default: resp_error <= 1'b1;
                        endcase
                    end
                end
                ST_RD: begin
                    resp_valid <= 1'b1;
                    resp_data  <= rd_ok_q ? ram_rdata : '0;
                    resp_error <= !rd_ok_q;
                    state      <= ST_RESP;
                end
`ifdef HEAP_ZERO_ON_ALLOC_EN
                ST_CLR: begin
                    clr_cnt_q <= clr_cnt_q + DATA_WIDTH'(1);
                    if (clr_cnt_q == N_AREA_W - DATA_WIDTH'(1)) begin
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heap_array_controller.sv
// Directed bench for heap_array_controller with a queue/array reference model.
module tb_heap_array_controller;

    localparam int DW = 12;
    localparam int NA = 2;
    localparam int NR = 2;
`ifdef HEAP_ZERO_ON_ALLOC_EN
    localparam int ALAT  = NR + 1;
    localparam int STALE = 0;
`else
    localparam int ALAT  = 1;
    localparam int STALE = 33;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = '0;
    logic [DW-1:0] req_array = '0;
    logic [DW-1:0] req_index = '0;
    logic [DW-1:0] req_data = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_error;
    logic [DW-1:0] allocs;

    always #5 clock = ~clock;

    heap_array_controller #(.DATA_WIDTH(DW), .N_ARRAYS(NA), .N_AREA(NR)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_array  (req_array),
        .req_index  (req_index),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .allocs     (allocs)
    );

    typedef struct {
        int due;
        int data;
        bit err;
    } resp_t;

    // Reference model state
    resp_t q[$];
    int    cyc = 0;
    int    busy_until = -1;
    bit    m_live [NA];
    int    m_size [NA];
    int    m_stack[$];
    int    m_allocs = 0;
    int    m_mem  [NA*NR];
    bit    started = 0;
    bit    accepted = 0;
    int    pin_data, pin_lat;
    bit    pin_err;

    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of one clock edge: reset, or acceptance of the presented request.
    task automatic model_edge();
        int a, i, h, lat, r_data;
        bit r_err;
        accepted = 0;
        if (reset) begin
            q.delete();
            m_stack.delete();
            busy_until = cyc;
            m_allocs = 0;
            for (int k = 0; k < NA; k++) begin
                m_live[k] = 0;
                m_size[k] = 0;
            end
            started = 1;
            return;
        end
        if (!started || !req_valid || cyc <= busy_until) return;
        a = int'(req_array);
        i = int'(req_index);
        lat = 1; r_data = 0; r_err = 0;
        case (req_op)
            3'd0: begin
                h = -1;
                if (m_stack.size() > 0) h = m_stack.pop_back();
                else if (m_allocs < NA) begin h = m_allocs; m_allocs++; end
                if (h < 0) r_err = 1;
                else begin
                    m_live[h] = 1;
                    m_size[h] = 0;
                    r_data = h;
`ifdef HEAP_ZERO_ON_ALLOC_EN
                    for (int k = 0; k < NR; k++) m_mem[h*NR+k] = 0;
                    lat = NR + 1;
`endif
                end
            end
            3'd1: begin
                if (a < NA && m_live[a]) begin
                    m_live[a] = 0;
                    m_stack.push_back(a);
                end else r_err = 1;
            end
            3'd2: begin
                lat = 2;
                if (a < NA && m_live[a] && i < NR) r_data = m_mem[a*NR+i];
                else r_err = 1;
            end
            3'd3: begin
                if (a < NA && m_live[a] && i < NR) begin
                    m_mem[a*NR+i] = int'(req_data);
                    if (i + 1 > m_size[a]) m_size[a] = i + 1;
                end else r_err = 1;
            end
            3'd4: begin
                if (a < NA && m_live[a]) r_data = m_size[a];
                else r_err = 1;
            end
            default: r_err = 1;
        endcase
        q.push_back('{due: cyc + lat, data: r_data, err: r_err});
        busy_until = cyc + lat;
        accepted = 1;
        check("pin_data", r_data, pin_data);
        check("pin_err", int'(r_err), int'(pin_err));
        check("pin_lat", lat, pin_lat);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    task automatic check_cycle();
        bit ev;
        if (!started) return;
        ev = (q.size() > 0) && (q[0].due == cyc);
        check("resp_valid", int'(resp_valid), int'(ev));
        check("req_ready", int'(req_ready), int'(cyc > busy_until));
        check("allocs", int'(allocs), m_allocs);
        if (ev) begin
            check("resp_data", int'(resp_data), q[0].data);
            check("resp_error", int'(resp_error), int'(q[0].err));
            void'(q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        cyc++;
        @(negedge clock);
        check_cycle();
    endtask

    task automatic present(input logic [2:0] op, input int a, input int i, input int d,
                           input int pd, input bit pe, input int pl);
        pin_data  = pd;
        pin_err   = pe;
        pin_lat   = pl;
        req_op    = op;
        req_array = DW'(a);
        req_index = DW'(i);
        req_data  = DW'(d);
        req_valid = 1'b1;
        for (int n = 0; n < 20 && !accepted; n++) step();
        check("accepted", int'(accepted), 1);
    endtask

    task automatic issue(input logic [2:0] op, input int a, input int i, input int d,
                         input int pd, input bit pe, input int pl, input bit hold);
        accepted = 0;
        present(op, a, i, d, pd, pe, pl);
        if (!hold) begin
            req_valid = 1'b0;
            req_array = DW'($urandom);
            req_index = DW'($urandom);
            req_data  = DW'($urandom);
        end
        for (int n = 0; n < 20 && q.size() > 0; n++) step();
        req_valid = 1'b0;
        check("resp_pending", q.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < NA*NR; k++) m_mem[k] = 0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("reset_resp_data", int'(resp_data), 0);
        check("reset_resp_error", int'(resp_error), 0);
        step();

        issue(3'd0, 0, 0, 0,  0, 0, ALAT, 0);
        issue(3'd0, 0, 0, 0,  1, 0, ALAT, 0);
        issue(3'd0, 0, 0, 0,  0, 1, 1, 0);
        check("allocs_full", int'(allocs), 2);

        issue(3'd3, 0, 0, 11, 0, 0, 1, 0);
        issue(3'd3, 0, 1, 22, 0, 0, 1, 0);
        issue(3'd3, 1, 1, 33, 0, 0, 1, 0);
        issue(3'd2, 0, 0, 0, 11, 0, 2, 0);
        issue(3'd2, 0, 1, 0, 22, 0, 2, 0);
        issue(3'd2, 1, 1, 0, 33, 0, 2, 0);
        issue(3'd4, 1, 0, 0,  2, 0, 1, 0);
        issue(3'd4, 0, 0, 0,  2, 0, 1, 0);

        issue(3'd3, 0, 0, 77, 0, 0, 1, 0);
        issue(3'd4, 0, 0, 0,  2, 0, 1, 0);
        issue(3'd2, 0, 0, 0, 77, 0, 2, 0);

        issue(3'd1, 1, 0, 0,  0, 0, 1, 0);
        issue(3'd1, 1, 0, 0,  0, 1, 1, 0);
        issue(3'd0, 0, 0, 0,  1, 0, ALAT, 0);
        issue(3'd4, 1, 0, 0,  0, 0, 1, 0);
        issue(3'd2, 1, 1, 0, STALE, 0, 2, 0);

        issue(3'd3, 0, 2, 5,  0, 1, 1, 1);
        issue(3'd2, 7, 0, 0,  0, 1, 2, 1);
        issue(3'd4, 0, 0, 0,  2, 0, 1, 0);
        issue(3'd2, 0, 1, 0, 22, 0, 2, 0);
        issue(3'd5, 0, 0, 0,  0, 1, 1, 0);
        issue(3'd1, 3, 0, 0,  0, 1, 1, 0);
        issue(3'd4, 7, 0, 0,  0, 1, 1, 0);

        issue(3'd3, 1, 0, 44, 0, 0, 1, 0);
        issue(3'd4, 1, 0, 0,  1, 0, 1, 0);
        issue(3'd2, 1, 0, 0, 44, 0, 2, 0);

        // Reset while a READ sits in its RAM-read cycle.
        accepted = 0;
        present(3'd2, 0, 0, 0, 77, 0, 2);
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", int'(req_ready), 1);
        check("abort_allocs", int'(allocs), 0);
        check("abort_no_resp", int'(resp_valid), 0);
        step();
        step();

        issue(3'd0, 0, 0, 0,  0, 0, ALAT, 0);
        issue(3'd0, 0, 0, 0,  1, 0, ALAT, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
